// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared opcodes, funct10 codes, sequencer states and legality decode
package riscv_pkg;

  localparam logic [6:0] OPC_LUI = 7'b0110111;
  localparam logic [6:0] OPC_OP  = 7'b0110011;

  // {funct7, funct3} for the supported register-register operations
  localparam logic [9:0] F10_ADD = 10'b0000000000;
  localparam logic [9:0] F10_SUB = 10'b0100000000;
  localparam logic [9:0] F10_XOR = 10'b0000000100;
  localparam logic [9:0] F10_OR  = 10'b0000000110;
  localparam logic [9:0] F10_AND = 10'b0000000111;

  typedef enum logic [2:0] {
    FETCH,
    WAIT,
    DECODE,
    EXEC,
    WB,
    HALT
  } seq_state_t;

  // Only LUI and the five listed OP encodings are executable; everything else traps.
  function automatic logic is_legal(input logic [31:0] insn);
    logic [9:0] f10;
    f10 = {insn[31:25], insn[14:12]};
    if (insn[6:0] == OPC_LUI) begin
      return 1'b1;
    end
    if (insn[6:0] == OPC_OP) begin
      return (f10 == F10_ADD) || (f10 == F10_SUB) || (f10 == F10_XOR) ||
             (f10 == F10_OR)  || (f10 == F10_AND);
    end
    return 1'b0;
  endfunction

endpackage

// File: rtl/riscv_core_seq_if.sv
// rtl/riscv_core_seq_if.sv - instruction-memory port and exec-unit port of the sequencer
interface riscv_core_seq_if #(
  parameter int XLEN = 32
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;

  logic [6:0]      ex_opcode;
  logic [2:0]      ex_funct3;
  logic [6:0]      ex_funct7;
  logic [19:0]     ex_imm;
  logic [XLEN-1:0] ex_rs1;
  logic [XLEN-1:0] ex_rs2;
  logic            ex_rd_enable_write;
  logic [XLEN-1:0] ex_rd;

  // Sequencer side
  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output ex_opcode, ex_funct3, ex_funct7, ex_imm, ex_rs1, ex_rs2,
    input  ex_rd_enable_write, ex_rd
  );

  // Memory / exec-unit side
  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  ex_opcode, ex_funct3, ex_funct7, ex_imm, ex_rs1, ex_rs2,
    output ex_rd_enable_write, ex_rd
  );
endinterface

// File: rtl/riscv_regfile.sv
// rtl/riscv_regfile.sv - 32-entry integer register file, two async reads, one sync write
module riscv_regfile #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [4:0]      ra1,
  input  logic [4:0]      ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  input  logic            we,
  input  logic [4:0]      wa,
  input  logic [XLEN-1:0] wd
);
  logic [XLEN-1:0] regs_q [32];
  logic [XLEN-1:0] regs_d [32];

  // Next register contents: single write port, writes to x0 are dropped
  always_comb begin
    regs_d = regs_q;
    if (we && (wa != 5'd0)) begin
      regs_d[wa] = wd;
    end
  end

  // Register storage, cleared on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rd1 = (ra1 == 5'd0) ? '0 : regs_q[ra1];
  assign rd2 = (ra2 == 5'd0) ? '0 : regs_q[ra2];
endmodule

// File: rtl/riscv_core_seq.sv
// rtl/riscv_core_seq.sv - multi-cycle fetch/decode/exec/writeback sequencer of the minimal core
module riscv_core_seq
  import riscv_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  riscv_core_seq_if.master    bus,
  output logic [XLEN-1:0]     pc,
  output logic [63:0]         instret,
  output logic                trap
);
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  seq_state_t      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     ir_q, ir_d;
  logic [XLEN-1:0] rs1_q, rs1_d, rs2_q, rs2_d;
  logic [XLEN-1:0] res_q, res_d;
  logic            res_we_q, res_we_d;
  logic [63:0]     instret_q, instret_d;
  logic            trap_q, trap_d;
  logic [XLEN-1:0] rf_rd1, rf_rd2;
  logic            req_valid;

  riscv_regfile #(.XLEN(XLEN)) u_rf (
    .clk   (clk),
    .rst_n (rst_n),
    .ra1   (ir_q[19:15]),
    .ra2   (ir_q[24:20]),
    .rd1   (rf_rd1),
    .rd2   (rf_rd2),
    .we    ((state_q == WB) && res_we_q),
    .wa    (ir_q[11:7]),
    .wd    (res_q)
  );

  // Request is gated by reset so nothing is offered while rst_n is held low
  assign req_valid          = (state_q == FETCH) && run && rst_n;
  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = pc_q;
  assign bus.ex_opcode      = ir_q[6:0];
  assign bus.ex_funct3      = ir_q[14:12];
  assign bus.ex_funct7      = ir_q[31:25];
  assign bus.ex_imm         = ir_q[31:12];
  assign bus.ex_rs1         = rs1_q;
  assign bus.ex_rs2         = rs2_q;
  assign pc                 = pc_q;
  assign instret            = instret_q;
  assign trap               = trap_q;

  // Next-state and datapath updates for the serial instruction walk
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    res_d     = res_q;
    res_we_d  = res_we_q;
    instret_d = instret_q;
    trap_d    = trap_q;
    case (state_q)
      FETCH: begin
        if (req_valid && bus.imem_req_ready) state_d = WAIT;
      end
      WAIT: begin
        if (bus.imem_rsp_valid) begin
          ir_d    = bus.imem_rsp_data;
          state_d = DECODE;
        end
      end
      DECODE: begin
        rs1_d = rf_rd1;
        rs2_d = rf_rd2;
        if (is_legal(ir_q)) begin
          state_d = EXEC;
        end else begin
          trap_d  = 1'b1;
          state_d = HALT;
        end
      end
      EXEC: begin
        res_d    = bus.ex_rd;
        res_we_d = bus.ex_rd_enable_write;
        state_d  = WB;
      end
      WB: begin
        pc_d      = pc_q + PC_STEP;
        instret_d = instret_q + 64'd1;
        state_d   = FETCH;
      end
      HALT:    state_d = HALT;
      default: state_d = HALT;
    endcase
  end

  // Architectural and sequencing state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      res_q     <= '0;
      res_we_q  <= 1'b0;
      instret_q <= '0;
      trap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      res_q     <= res_d;
      res_we_q  <= res_we_d;
      instret_q <= instret_d;
      trap_q    <= trap_d;
    end
  end
endmodule
